aes128_key_schedule: RTL and testbench
======================================

Name: aes128_key_schedule

Overview:
- Sequential AES-128 round-key generator. Accepts a 128-bit cipher key over a valid/ready handshake.
- Iterates the team's combinational key_expansion step once per clock (ports key, count, key_out) and stores round keys 0..NROUNDS.
- Serves the stored keys to the downstream cipher round datapath through a registered read port.
- Sits between the key-load interface and the AES-128 encryption core.

Parameters:
- NROUNDS, 10, number of expansion rounds. Legal range 1..10; values below 10 exist for reduced-round fault/side-channel experiments.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- key_in  input  128  cipher key, sampled on accept; byte 0 is in [127:120]
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a key; high only in IDLE
- rk_addr  input  4  round-key index to read
- rk_out  output  128  registered round key, indexed by rk_addr of the previous cycle
- busy  output  1  expansion in progress
- done  output  1  one-cycle pulse when all round keys are written
- keys_valid  output  1  level; the stored key set is complete and coherent

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values while rst_n=0:
  - state=IDLE, round counter=0, all NROUNDS+1 key registers=0
  - rk_out=0, busy=0, done=0, keys_valid=0, key_ready=1
- key_ready is combinational: key_ready = (state==IDLE).
- States: IDLE and EXPAND.
- IDLE:
  - Accept occurs when key_valid && key_ready at a rising edge, edge T0.
  - On accept: rk[0] <= key_in, round <= 0, keys_valid <= 0, busy <= 1, state <= EXPAND.
  - key_valid is ignored whenever key_ready=0. There is no queueing.
- EXPAND:
  - Each edge: rk[round+1] <= key_expansion(rk[round], count=round), then round <= round+1.
  - count=r selects rcon 01,02,04,08,10,20,40,80,1b,36 (in byte [31:24]) for r=0..9.
  - One round per cycle.
- Completion:
  - On the edge where round==NROUNDS-1, rk[NROUNDS] is written and the same edge sets state <= IDLE, busy <= 0, keys_valid <= 1, done <= 1.
  - done clears on the following edge.
  - Latency from accept edge T0 to done high is NROUNDS edges, i.e. T10 for the default.
- Back-to-back keys:
  - A new key may be accepted in the cycle done is high, because state is IDLE.
  - That accept clears keys_valid on the same edge done falls.
- Read port:
  - rk_out <= (rk_addr <= NROUNDS) ? rk[rk_addr] : 128'h0, registered, 1-cycle latency.
  - Reads are always permitted. During EXPAND they return whatever is currently stored (old or partially new keys); keys_valid=0 flags this.
- Width rules:
  - Round counter is 4 bits and never exceeds NROUNDS-1 in EXPAND.
  - Key registers are not written outside accept or EXPAND.
- Reset mid-expansion (rst_n low at any time): immediate return to the reset values above. All keys are zeroed, so no partial key material is retained. done never fires for the aborted key.
- Key_in changing after the accept edge has no effect.

Test Plan:
1. Reset, then key_in=2b7e151628aed2a6abf7158809cf4f3c with key_valid=1 for one cycle -> busy high for 10 cycles; done pulses once at T10; keys_valid=1. Reads give:
   - rk_addr=0 -> 2b7e151628aed2a6abf7158809cf4f3c
   - rk_addr=1 -> a0fafe1788542cb123a339392a6c7605
   - rk_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6
2. key_in=0 -> rk1=62636363626363636263636362636363; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
3. key_valid held high with a different key during EXPAND -> key_ready=0, the second key is ignored, and the stored keys match the first key.
4. rst_n pulsed low at T5 -> busy=0, done never asserts, keys_valid=0, and every rk_addr 0..10 reads 0.
5. New key accepted in the done cycle -> keys_valid falls next edge; a second done arrives 10 edges later with correct rk10; rk_addr=11..15 reads 0.
6. NROUNDS=1 build with the FIPS key -> done at T1, and rk1=a0fafe1788542cb123a339392a6c7605.

Source files
------------

// File: rtl/aes128_key_schedule.sv
// AES-128 round-key generator: one key_expansion step per clock, round keys
// 0..NROUNDS held in registers and served through a registered read port.

module key_expansion (
    input  logic [127:0] key,
    input  logic [3:0]   count,
    output logic [127:0] key_out
);
    // Forward S-box, byte 0 in the top bits.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7, temp;
    logic [7:0]  rcon;

    always_comb begin
        case (count)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key;
    // RotWord then SubWord on the last word of the previous round key.
    assign temp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
                  ^ {rcon, 24'h000000};
    assign w4 = w0 ^ temp;
    assign w5 = w1 ^ w4;
    assign w6 = w2 ^ w5;
    assign w7 = w3 ^ w6;
    assign key_out = {w4, w5, w6, w7};
endmodule

module aes128_key_schedule #(
    parameter int NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);
    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic         keys_valid_q, keys_valid_d;
    logic         done_q, done_d;
    logic [127:0] rk_out_q, rd_d;
    logic [127:0] rk_q [0:NROUNDS];
    logic [127:0] exp_src, exp_key;
    logic         load, step;

    key_expansion u_step (
        .key     (exp_src),
        .count   (round_q),
        .key_out (exp_key)
    );

    always_comb begin
        exp_src = rk_q[0];
        for (int i = 1; i < NROUNDS; i++) begin
            if (round_q == 4'(i)) exp_src = rk_q[i];
        end
    end

    // Addresses above NROUNDS fall through to zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i <= NROUNDS; i++) begin
            if (rk_addr == 4'(i)) rd_d = rk_q[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    load         = 1'b1;
                    round_d      = 4'd0;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                step    = 1'b1;
                round_d = round_q + 4'd1;
                if (round_q == LAST_ROUND) begin
                    round_d      = 4'd0;
                    state_d      = IDLE;
                    keys_valid_d = 1'b1;
                    done_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            round_q      <= 4'd0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rk_out_q     <= '0;
            for (int i = 0; i <= NROUNDS; i++) rk_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
            rk_out_q     <= rd_d;
            if (load) rk_q[0] <= key_in;
            for (int i = 1; i <= NROUNDS; i++) begin
                if (step && round_q == 4'(i - 1)) rk_q[i] <= exp_key;
            end
        end
    end

    assign key_ready  = (state_q == IDLE);
    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign rk_out     = rk_out_q;
endmodule

// File: tb/tb_aes128_key_schedule.sv
// Directed bench for aes128_key_schedule: FIPS-197 and all-zero key vectors,
// overlap rejection, mid-expansion reset, back-to-back keys, NROUNDS=1 build.

module tb_aes128_key_schedule;
    logic         clk;
    logic         rst_n;
    logic [127:0] key_in, key_in1;
    logic         key_valid, key_valid1;
    logic         key_ready, key_ready1;
    logic [3:0]   rk_addr, rk_addr1;
    logic [127:0] rk_out, rk_out1;
    logic         busy, busy1, done, done1, keys_valid, keys_valid1;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    aes128_key_schedule dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .rk_addr(rk_addr), .rk_out(rk_out), .busy(busy),
        .done(done), .keys_valid(keys_valid)
    );

    aes128_key_schedule #(.NROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_in(key_in1), .key_valid(key_valid1),
        .key_ready(key_ready1), .rk_addr(rk_addr1), .rk_out(rk_out1), .busy(busy1),
        .done(done1), .keys_valid(keys_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_check(input logic [3:0] addr, input logic [127:0] exp, input string tag);
        rk_addr = addr;
        tick();
        check($sformatf("%s rk[%0d]", tag, addr), rk_out, exp);
    endtask

    task automatic accept(input logic [127:0] k);
        key_in    = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Counts edges until done, checking busy stays high meanwhile.
    task automatic wait_done(input int exp_lat, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            check({tag, " busy"}, {127'h0, busy}, 128'h1);
            tick();
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(exp_lat));
        check({tag, " busy_end"}, {127'h0, busy}, 128'h0);
        check({tag, " keys_valid"}, {127'h0, keys_valid}, 128'h1);
    endtask

    initial begin
        int dcount;
        rst_n      = 1'b0;
        key_in     = '0;
        key_valid  = 1'b0;
        rk_addr    = 4'd0;
        key_in1    = '0;
        key_valid1 = 1'b0;
        rk_addr1   = 4'd0;
        #1;
        check("reset key_ready", {127'h0, key_ready}, 128'h1);
        check("reset busy", {127'h0, busy}, 128'h0);
        check("reset done", {127'h0, done}, 128'h0);
        check("reset keys_valid", {127'h0, keys_valid}, 128'h0);
        check("reset rk_out", rk_out, 128'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 key
        accept(FIPS_KEY);
        check("t1 key_ready", {127'h0, key_ready}, 128'h0);
        wait_done(10, "t1");
        tick();
        check("t1 done_pulse", {127'h0, done}, 128'h0);
        for (int a = 0; a <= 10; a++) read_check(4'(a), fips_rk[a], "t1");

        // All-zero key
        accept(128'h0);
        wait_done(10, "t2");
        read_check(4'd1, 128'h62636363626363636263636362636363, "t2");
        read_check(4'd2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, "t2");
        read_check(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "t2");

        // Second key presented during EXPAND must be ignored
        accept(FIPS_KEY);
        key_in    = OTHER_KEY;
        key_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("t3 key_ready", {127'h0, key_ready}, 128'h0);
            tick();
        end
        key_valid = 1'b0;
        wait_done(5, "t3");
        read_check(4'd0, FIPS_KEY, "t3");
        read_check(4'd1, fips_rk[1], "t3");
        read_check(4'd10, fips_rk[10], "t3");

        // Reset during expansion
        accept(128'h0);
        for (int c = 0; c < 4; c++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t4 busy", {127'h0, busy}, 128'h0);
        check("t4 keys_valid", {127'h0, keys_valid}, 128'h0);
        check("t4 key_ready", {127'h0, key_ready}, 128'h1);
        check("t4 rk_out", rk_out, 128'h0);
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("t4 done_count", 128'(dcount), 128'h0);
        check("t4 keys_valid_after", {127'h0, keys_valid}, 128'h0);
        for (int a = 0; a <= 10; a++) read_check(4'(a), 128'h0, "t4");

        // Back-to-back: new key accepted in the done cycle
        accept(FIPS_KEY);
        wait_done(10, "t5a");
        check("t5 key_ready_in_done", {127'h0, key_ready}, 128'h1);
        accept(128'h0);
        check("t5 keys_valid_fall", {127'h0, keys_valid}, 128'h0);
        check("t5 done_fall", {127'h0, done}, 128'h0);
        check("t5 busy", {127'h0, busy}, 128'h1);
        wait_done(10, "t5b");
        read_check(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, "t5");
        for (int a = 11; a <= 15; a++) read_check(4'(a), 128'h0, "t5");

        // NROUNDS=1 build
        key_in1    = FIPS_KEY;
        key_valid1 = 1'b1;
        tick();
        key_valid1 = 1'b0;
        check("t6 busy", {127'h0, busy1}, 128'h1);
        tick();
        check("t6 done", {127'h0, done1}, 128'h1);
        check("t6 keys_valid", {127'h0, keys_valid1}, 128'h1);
        rk_addr1 = 4'd1;
        tick();
        check("t6 rk[1]", rk_out1, 128'ha0fafe1788542cb123a339392a6c7605);
        check("t6 done_fall", {127'h0, done1}, 128'h0);
        rk_addr1 = 4'd0;
        tick();
        check("t6 rk[0]", rk_out1, FIPS_KEY);
        rk_addr1 = 4'd2;
        tick();
        check("t6 rk[2]", rk_out1, 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
